// File: rtl/path_delay_monitor.sv
// Path delay monitor: launches alternating rise/fall edges on a spy path
// and measures launch-to-capture delay in clk cycles.
//
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   start             - one-cycle pulse; begins a run when idle
//   path_out          - asynchronous path sink (synchronised by 2 flops)
//   path_in           - registered drive of the path source
//   busy, done        - run in progress / one-cycle completion pulse
//   last_dly, min_dly, max_dly, sum_dly - per-run delay statistics
//   timeout, alarm    - sticky flags for the current run
module path_delay_monitor #(
    parameter int CW         = 8,
    parameter int NTRIALS    = 16,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 200,
    parameter int THRESH     = 10,
    parameter int EXPECT_INV = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          path_out,
    output logic                          path_in,
    output logic                          busy,
    output logic                          done,
    output logic [CW-1:0]                 last_dly,
    output logic [CW-1:0]                 min_dly,
    output logic [CW-1:0]                 max_dly,
    output logic [CW+$clog2(NTRIALS):0]   sum_dly,
    output logic                          timeout,
    output logic                          alarm
);

    localparam int SW = CW + $clog2(NTRIALS) + 1;
    localparam int IW = $clog2(NTRIALS + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_L       = CW'(TIMEOUT);
    localparam logic [CW-1:0] THR_L       = CW'(THRESH);
    localparam logic [IW-1:0] NT_L        = IW'(NTRIALS);
    localparam logic          INV_L       = (EXPECT_INV != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_RECORD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            pin_q, pin_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   min_q, min_d;
    logic [CW-1:0]   max_q, max_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic            tmo_q, tmo_d;
    logic            alarm_q, alarm_d;
    // Low for the first edge after reset release so a start coincident
    // with the release is not accepted.
    logic            armed_q, armed_d;
    logic            expected;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sync1_d  = path_out;
        sync2_d  = sync1_q;
        pin_d    = pin_q;
        last_d   = last_q;
        min_d    = min_q;
        max_d    = max_q;
        sum_d    = sum_q;
        tmo_d    = tmo_q;
        alarm_d  = alarm_q;
        armed_d  = 1'b1;
        expected = pin_q ^ INV_L;

        unique case (state_q)
            S_IDLE: begin
                if (start && armed_q) begin
                    state_d = S_SETTLE;
                    min_d   = '1;
                    max_d   = '0;
                    sum_d   = '0;
                    tmo_d   = 1'b0;
                    alarm_d = 1'b0;
                    idx_d   = '0;
                    pin_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    pin_d   = ~pin_q;
                    cnt_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                // sync1 is what sync2 becomes at this edge, so a match
                // here ends the trial exactly at edge cnt_d.
                cnt_d = cnt_q + 1'b1;
                if (sync1_q == expected) begin
                    state_d = S_RECORD;
                end else if (cnt_d == TMO_L) begin
                    state_d = S_RECORD;
                    tmo_d   = 1'b1;
                    alarm_d = 1'b1;
                end
            end
            S_RECORD: begin
                last_d = cnt_q;
                if (cnt_q < min_q) begin
                    min_d = cnt_q;
                end
                if (cnt_q > max_q) begin
                    max_d = cnt_q;
                end
                sum_d = sum_q + SW'(cnt_q);
                if (cnt_q > THR_L) begin
                    alarm_d = 1'b1;
                end
                idx_d = idx_q + 1'b1;
                cnt_d = '0;
                if (idx_d == NT_L) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pin_q   <= 1'b0;
            last_q  <= '0;
            min_q   <= '1;
            max_q   <= '0;
            sum_q   <= '0;
            tmo_q   <= 1'b0;
            alarm_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pin_q   <= pin_d;
            last_q  <= last_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            alarm_q <= alarm_d;
            armed_q <= armed_d;
        end
    end

    assign path_in  = pin_q;
    assign busy     = (state_q == S_SETTLE) || (state_q == S_MEASURE) ||
                      (state_q == S_RECORD);
    assign done     = (state_q == S_DONE);
    assign last_dly = last_q;
    assign min_dly  = min_q;
    assign max_dly  = max_q;
    assign sum_dly  = sum_q;
    assign timeout  = tmo_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_path_delay_monitor.sv
// Self-checking bench for path_delay_monitor using a delay-line path
// model with independent rise/fall latencies and a stuck-low path.
module tb_path_delay_monitor;

    localparam int NT  = 4;
    localparam int SC  = 4;
    localparam int TMO = 200;
    localparam int TH  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic        path_out = 1'b1;
    logic        path_out0 = 1'b0;

    logic        path_in, busy, done, timeout, alarm;
    logic [7:0]  last_dly, min_dly, max_dly;
    logic [10:0] sum_dly;

    logic        path_in0, busy0, done0, timeout0, alarm0;
    logic [7:0]  last0, min0, max0;
    logic [10:0] sum0;

    int errors = 0;
    int checks = 0;

    int d_rise = 0;
    int d_fall = 0;
    int age = 0;
    logic pin_seen = 1'b0;
    logic line_v = 1'b0;
    int toggles = 0;
    int busy_cyc = 0;
    int n_done = 0;
    int n_done0 = 0;

    path_delay_monitor #(
        .CW(8), .NTRIALS(NT), .SETTLE_CYC(SC),
        .TIMEOUT(TMO), .THRESH(TH), .EXPECT_INV(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .path_out(path_out), .path_in(path_in),
        .busy(busy), .done(done), .last_dly(last_dly),
        .min_dly(min_dly), .max_dly(max_dly), .sum_dly(sum_dly),
        .timeout(timeout), .alarm(alarm)
    );

    path_delay_monitor #(
        .CW(8), .NTRIALS(NT), .SETTLE_CYC(SC),
        .TIMEOUT(TMO), .THRESH(TH), .EXPECT_INV(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .path_out(path_out0), .path_in(path_in0),
        .busy(busy0), .done(done0), .last_dly(last0),
        .min_dly(min0), .max_dly(max0), .sum_dly(sum0),
        .timeout(timeout0), .alarm(alarm0)
    );

    always #5 clk = ~clk;

    // Path model: path_in change reaches the line d cycles later
    // (d = 0 behaves like a zero-delay loopback), output inverted.
    always @(negedge clk) begin
        if (path_in !== pin_seen) begin
            pin_seen = path_in;
            age = 0;
            toggles++;
        end else if (age < 100000) begin
            age++;
        end
        if (age >= (path_in ? d_rise : d_fall)) line_v = path_in;
        path_out = ~line_v;
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) n_done++;
        if (done0 === 1'b1) n_done0++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_main();
        int n0;
        int i;
        tick(1);
        toggles = 0;
        busy_cyc = 0;
        n0 = n_done;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        i = 0;
        while (n_done == n0 && i < 5000) begin
            tick(1);
            i++;
        end
        checks++;
        if (n_done == n0) begin
            errors++;
            $display("FAIL run_done: got no done, need 1 pulse");
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({path_in, busy, done, timeout, alarm} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags: got %b need 00000",
                     {path_in, busy, done, timeout, alarm});
        end
        checks++;
        if (min_dly !== 8'hff || max_dly !== 8'h00 || last_dly !== 8'h00) begin
            errors++;
            $display("FAIL rst_minmax: got %h/%h/%h need ff/00/00",
                     min_dly, max_dly, last_dly);
        end
        checks++;
        if (sum_dly !== 11'd0 || min0 !== 8'hff) begin
            errors++;
            $display("FAIL rst_sum: got %0d/%h need 0/ff", sum_dly, min0);
        end
        start = 1'b1;
        rst_n = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_at_release: busy %b need 0", busy);
        end
    endtask

    task automatic test_loopback();
        d_rise = 0;
        d_fall = 0;
        tick(5);
        run_main();
        checks++;
        if (last_dly !== 8'd2 || min_dly !== 8'd2 || max_dly !== 8'd2) begin
            errors++;
            $display("FAIL loop_lmm: got %0d/%0d/%0d need 2/2/2",
                     last_dly, min_dly, max_dly);
        end
        checks++;
        if (sum_dly !== 11'd8) begin
            errors++;
            $display("FAIL loop_sum: got %0d need 8", sum_dly);
        end
        checks++;
        if (alarm !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL loop_flags: got %b%b need 00", alarm, timeout);
        end
        checks++;
        if (busy_cyc != NT * (SC + 2 + 1)) begin
            errors++;
            $display("FAIL loop_busy: got %0d need %0d",
                     busy_cyc, NT * (SC + 3));
        end
        tick(10);
        checks++;
        if (n_done != 1 || toggles != NT) begin
            errors++;
            $display("FAIL loop_done: got done=%0d tog=%0d need 1/%0d",
                     n_done, toggles, NT);
        end
    endtask

    task automatic test_fixed_delay();
        d_rise = 5;
        d_fall = 5;
        tick(10);
        run_main();
        checks++;
        if (min_dly !== 8'd7 || max_dly !== 8'd7 || sum_dly !== 11'd28 ||
            alarm !== 1'b0) begin
            errors++;
            $display("FAIL d5: got %0d/%0d/%0d al=%b need 7/7/28 al=0",
                     min_dly, max_dly, sum_dly, alarm);
        end
        d_rise = 9;
        d_fall = 9;
        tick(12);
        run_main();
        checks++;
        if (last_dly !== 8'd11 || sum_dly !== 11'd44 || alarm !== 1'b1 ||
            timeout !== 1'b0) begin
            errors++;
            $display("FAIL d9: got %0d/%0d al=%b to=%b need 11/44 al=1 to=0",
                     last_dly, sum_dly, alarm, timeout);
        end
    endtask

    task automatic test_asym();
        d_rise = 3;
        d_fall = 6;
        tick(12);
        run_main();
        checks++;
        if (min_dly !== 8'd5 || max_dly !== 8'd8 || sum_dly !== 11'd26 ||
            last_dly !== 8'd8) begin
            errors++;
            $display("FAIL asym: got %0d/%0d/%0d/%0d need 5/8/26/8",
                     min_dly, max_dly, sum_dly, last_dly);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int e_min;
            int e_max;
            int e_sum;
            int e_last;
            int d;
            logic e_al;
            d_rise = int'($urandom_range(0, 12));
            d_fall = int'($urandom_range(0, 12));
            e_min = 255;
            e_max = 0;
            e_sum = 0;
            e_last = 0;
            e_al = 1'b0;
            for (int t = 0; t < NT; t++) begin
                d = ((t % 2 == 0) ? d_rise : d_fall) + 2;
                if (d < e_min) e_min = d;
                if (d > e_max) e_max = d;
                e_sum += d;
                e_last = d;
                if (d > TH) e_al = 1'b1;
            end
            tick(16);
            run_main();
            checks++;
            if (int'(min_dly) != e_min || int'(max_dly) != e_max ||
                int'(sum_dly) != e_sum || int'(last_dly) != e_last ||
                alarm !== e_al || timeout !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d r=%0d f=%0d: got %0d/%0d/%0d/%0d al=%b to=%b need %0d/%0d/%0d/%0d al=%b to=0",
                         r, d_rise, d_fall, min_dly, max_dly, sum_dly,
                         last_dly, alarm, timeout, e_min, e_max, e_sum,
                         e_last, e_al);
            end
        end
    endtask

    task automatic test_stuck();
        int i;
        tick(2);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        i = 0;
        while (last0 == 8'd0 && i < 2000) begin
            tick(1);
            i++;
        end
        checks++;
        if (last0 !== 8'(TMO) || timeout0 !== 1'b1 || alarm0 !== 1'b1) begin
            errors++;
            $display("FAIL stuck_first: got %0d to=%b al=%b need %0d to=1 al=1",
                     last0, timeout0, alarm0, TMO);
        end
        i = 0;
        while (n_done0 == 0 && i < 2000) begin
            tick(1);
            i++;
        end
        checks++;
        if (n_done0 != 1 || min0 !== 8'd1 || max0 !== 8'(TMO) ||
            sum0 !== 11'd402) begin
            errors++;
            $display("FAIL stuck_run: got done=%0d %0d/%0d/%0d need 1 1/%0d/402",
                     n_done0, min0, max0, sum0, TMO);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        int n0;
        d_rise = 5;
        d_fall = 5;
        tick(12);
        toggles = 0;
        n0 = n_done;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        i = 0;
        while (toggles < 3 && i < 500) begin
            tick(1);
            i++;
        end
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({path_in, busy, done, timeout, alarm} !== 5'b0 ||
            min_dly !== 8'hff || max_dly !== 8'h00 ||
            last_dly !== 8'h00 || sum_dly !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: got pi=%b b=%b %h/%h/%h/%0d need 0/0 ff/00/00/0",
                     path_in, busy, min_dly, max_dly, last_dly, sum_dly);
        end
        tick(3);
        rst_n = 1'b1;
        tick(40);
        checks++;
        if (n_done != n0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone: got done=%0d busy=%b need %0d/0",
                     n_done - n0, busy, 0);
        end
        d_rise = 0;
        d_fall = 0;
        tick(5);
        run_main();
        checks++;
        if (min_dly !== 8'd2 || max_dly !== 8'd2 || sum_dly !== 11'd8 ||
            alarm !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_rerun: got %0d/%0d/%0d al=%b need 2/2/8 al=0",
                     min_dly, max_dly, sum_dly, alarm);
        end
    endtask

    task automatic test_busy_start();
        int i;
        int n0;
        d_rise = 0;
        d_fall = 0;
        tick(5);
        toggles = 0;
        busy_cyc = 0;
        n0 = n_done;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        i = 0;
        while (toggles < 1 && i < 100) begin
            tick(1);
            i++;
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        i = 0;
        while (n_done == n0 && i < 1000) begin
            tick(1);
            i++;
        end
        tick(60);
        checks++;
        if (n_done - n0 != 1 || toggles != NT) begin
            errors++;
            $display("FAIL busy_start: got done=%0d tog=%0d need 1/%0d",
                     n_done - n0, toggles, NT);
        end
        checks++;
        if (busy_cyc != NT * (SC + 3) || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_len: got %0d busy=%b need %0d/0",
                     busy_cyc, busy, NT * (SC + 3));
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_fixed_delay();
        test_asym();
        test_random();
        test_stuck();
        test_reset_mid();
        test_busy_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/path_delay_monitor.md
Name: path_delay_monitor

Overview:
- Downstream consumer of a single-path spy net. It drives the path source net (path_in → N382-equivalent) and observes the path sink (path_out ← N11334-equivalent).
- It launches alternating rise/fall transitions and measures the launch-to-capture delay in clk cycles through a 2-flop synchroniser.
- It accumulates min/max/sum over NTRIALS launches and raises alarm when any trial is slow or times out.
- Feeds the delay-comparison/reporting logic of the spy harness.

Parameters:
- CW, 8: width of the per-trial cycle counter and of min/max/last.
- NTRIALS, 16: launches per run (≥2). Trials alternate rise, fall, rise, …
- SETTLE_CYC, 4: cycles path_in is held static before each launch (≥1).
- TIMEOUT, 200: counter value at which a trial is aborted (< 2^CW).
- THRESH, 10: per-trial delay above which alarm is set.
- EXPECT_INV, 1: 1 means path_out settles to ~path_in; 0 means to path_in.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse; begins a run when idle.
- path_out, in, 1: asynchronous path sink, synchronised internally by 2 flops.
- path_in, out, 1: registered drive of the path source.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse when a run completes.
- last_dly, out, CW: delay of the most recent trial.
- min_dly, out, CW: minimum delay over the run.
- max_dly, out, CW: maximum delay over the run.
- sum_dly, out, CW+$clog2(NTRIALS)+1: sum of delays over the run.
- timeout, out, 1: sticky; some trial reached TIMEOUT.
- alarm, out, 1: sticky; timeout, or some trial delay > THRESH.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, except min_dly = all-ones.
  - Synchroniser flops 0, state IDLE, trial index 0.
  - Reset mid-run aborts immediately. No done pulse after release.
- States: IDLE → SETTLE → MEASURE → RECORD → (SETTLE | DONE) → IDLE.
- IDLE:
  - start=1 → SETTLE.
  - On entry to SETTLE from IDLE, clear: stats (min=all-ones, max=0, sum=0), timeout, alarm, trial index, path_in=0.
  - busy=1 from the next cycle.
- SETTLE:
  - Hold path_in; count SETTLE_CYC cycles.
  - On the last cycle, register path_in <= ~path_in (launch edge E0), clear the counter, go MEASURE.
- MEASURE:
  - The counter increments by 1 each edge.
  - expected = path_in ^ EXPECT_INV.
  - The trial ends at the first edge Ek after which sync2 == expected. Delay = k.
  - With a zero-delay loopback, the result is 2 (synchroniser latency).
  - Glitches that momentarily match are counted as the end; no filtering.
  - If the counter reaches TIMEOUT before a match: delay = TIMEOUT, set timeout and alarm.
- RECORD (1 cycle):
  - last_dly = delay.
  - min/max updated with unsigned compare; ties leave the value unchanged.
  - sum += delay; the sum never overflows by width rule.
  - If delay > THRESH, set alarm.
  - Increment trial index. If index == NTRIALS → DONE, else → SETTLE.
- DONE: pulse done for 1 cycle, busy=0, go IDLE. Statistics hold until the next accepted start.
- start while busy or in DONE is ignored.
- start in the same cycle as the rst_n release edge is ignored.
- path_in is never changed outside the SETTLE→MEASURE transition, so exactly NTRIALS edges occur per run.
- Pre-launch check: if sync2 already equals the post-launch expected value at launch (path stuck), the measurement still counts from E0 and ends at delay 1. This is reported as-is; the harness flags delay < 2 as stuck.

Test Plan:
- Loopback model path_out = path_in ^ 1, EXPECT_INV=1, NTRIALS=4, start pulse:
  - last/min/max = 2, sum = 8.
  - alarm = 0, timeout = 0.
  - done pulses once.
  - busy high for 4*(SETTLE_CYC+k+1)+… cycles, checked against the FSM cycle count.
- Path model with 5-cycle registered delay: all trials give 7, sum = 28 (NTRIALS=4), alarm = 0. Raise the delay to 9 cycles: delay 11 > THRESH, so alarm = 1, timeout = 0.
- Asymmetric model (rise 3 cycles, fall 6 cycles extra):
  - min = 5, max = 8.
  - sum = 2*5 + 2*8 = 26.
  - last = 8.
- path_out tied 0 with EXPECT_INV=0:
  - The first launch (path_in=1) times out: last = TIMEOUT, timeout = 1, alarm = 1.
  - The run still completes all trials and done pulses.
- Reset mid-MEASURE of trial 2: all outputs return to reset values asynchronously, no done pulse. A new start yields a clean run matching scenario 1.
- Second start while busy, pulsed in SETTLE and in MEASURE: ignored. Exactly NTRIALS path_in toggles and a single done pulse.
